// File: rtl/uart_pkg.sv
// Shared constants and state typedefs for the simplex UART loopback link.
package uart_pkg;
    localparam int DATA_W = 8;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_STOP} rx_state_t;

    // Bit-period counter width; a 1-cycle period still needs one flop.
    function automatic int cnt_w(input int cpb);
        return (cpb > 1) ? $clog2(cpb) : 1;
    endfunction
endpackage

// File: rtl/uart_simplex_rx.sv
// Receiver: registers the serial line, times each bit and samples it on the
// last cycle of its period, then publishes the word if the stop bit is valid.
module uart_simplex_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1,
    parameter int DATA_W       = uart_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              line,
    output logic [DATA_W-1:0] dout,
    output logic              done
);
    localparam int CW = cnt_w(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    rx_state_t         state;
    logic              line_q;
    logic [CW-1:0]     cnt;
    logic [BW-1:0]     bit_idx;
    logic [DATA_W-1:0] sh;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RX_IDLE;
            line_q  <= STOP_BIT;
            cnt     <= '0;
            bit_idx <= '0;
            sh      <= '0;
            dout    <= '0;
            done    <= 1'b0;
        end else if (clr) begin
            state   <= RX_IDLE;
            line_q  <= STOP_BIT;
            cnt     <= '0;
            bit_idx <= '0;
            done    <= 1'b0;
        end else begin
            line_q <= line;
            done   <= 1'b0;
            case (state)
                RX_IDLE: begin
                    // Detection already consumed the first cycle of the start bit;
                    // slot 0 of DATA covers whatever remains of it.
                    if (line_q == START_BIT) begin
                        state <= RX_DATA;
                        if (CLKS_PER_BIT == 1) begin
                            bit_idx <= BW'(1);
                            cnt     <= '0;
                        end else begin
                            bit_idx <= '0;
                            cnt     <= CW'(1);
                        end
                    end
                end
                RX_DATA: begin
                    if (cnt == LAST) begin
                        cnt <= '0;
                        if (bit_idx != '0) sh <= {line_q, sh[DATA_W-1:1]};
                        if (bit_idx == BW'(DATA_W)) state <= RX_STOP;
                        else bit_idx <= bit_idx + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= RX_IDLE;
                        if (line_q == STOP_BIT) begin
                            dout <= sh;
                            done <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/uart_simplex.sv
// Simplex UART loopback: falling-edge-triggered transmitter driving an
// internal serial line that feeds the receiver.
module uart_simplex
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1,
    parameter int DATA_W       = uart_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              done
);
    localparam int CW = cnt_w(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_W);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    tx_state_t         tx_state;
    logic              line;
    logic              start_q;
    logic [CW-1:0]     tx_cnt;
    logic [IW-1:0]     tx_bit;
    logic [DATA_W-1:0] tx_sh;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            line     <= STOP_BIT;
            start_q  <= 1'b1;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_sh    <= '0;
        end else begin
            start_q <= start;
            if (stop) begin
                tx_state <= TX_IDLE;
                line     <= STOP_BIT;
                tx_cnt   <= '0;
                tx_bit   <= '0;
            end else begin
                case (tx_state)
                    TX_IDLE: begin
                        if (start_q && !start) begin
                            tx_state <= TX_START;
                            line     <= START_BIT;
                            tx_sh    <= din;
                            tx_cnt   <= '0;
                        end
                    end
                    TX_START: begin
                        if (tx_cnt == LAST) begin
                            tx_cnt   <= '0;
                            tx_bit   <= '0;
                            tx_state <= TX_DATA;
                            line     <= tx_sh[0];
                        end else begin
                            tx_cnt <= tx_cnt + 1'b1;
                        end
                    end
                    TX_DATA: begin
                        if (tx_cnt == LAST) begin
                            tx_cnt <= '0;
                            if (tx_bit == IW'(DATA_W - 1)) begin
                                tx_state <= TX_STOP;
                                line     <= STOP_BIT;
                            end else begin
                                tx_bit <= tx_bit + 1'b1;
                                tx_sh  <= tx_sh >> 1;
                                line   <= tx_sh[1];
                            end
                        end else begin
                            tx_cnt <= tx_cnt + 1'b1;
                        end
                    end
                    TX_STOP: begin
                        if (tx_cnt == LAST) begin
                            tx_cnt   <= '0;
                            tx_state <= TX_IDLE;
                        end else begin
                            tx_cnt <= tx_cnt + 1'b1;
                        end
                    end
                    default: tx_state <= TX_IDLE;
                endcase
            end
        end
    end

    uart_simplex_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .DATA_W      (DATA_W)
    ) u_rx (
        .clk (clk),
        .rst (rst),
        .clr (stop),
        .line(line),
        .dout(dout),
        .done(done)
    );
endmodule

// File: tb/tb_uart_simplex.sv
// Bench for uart_simplex: two instances (1 and 4 clocks per bit) checked
// against a frame-level model of line bits, done timing and dout.
module tb_uart_simplex;
    logic       clk;
    logic       rst;
    logic       start_v [2];
    logic       stop_v  [2];
    logic [7:0] din_v   [2];
    logic [7:0] dout_v  [2];
    logic       done_v  [2];
    logic       line_v  [2];
    logic [7:0] exp_dout [2];
    int         errors;
    int         checks;

    uart_simplex #(.CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start_v[0]), .stop(stop_v[0]),
        .din(din_v[0]), .dout(dout_v[0]), .done(done_v[0])
    );
    uart_simplex #(.CLKS_PER_BIT(4)) dut4 (
        .clk(clk), .rst(rst), .start(start_v[1]), .stop(stop_v[1]),
        .din(din_v[1]), .dout(dout_v[1]), .done(done_v[1])
    );
    assign line_v[0] = dut1.line;
    assign line_v[1] = dut4.line;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input int s, input string tag);
        chk({tag, "_line"}, {7'd0, line_v[s]}, 8'd1);
        chk({tag, "_done"}, {7'd0, done_v[s]}, 8'd0);
        chk({tag, "_dout"}, dout_v[s], exp_dout[s]);
    endtask

    task automatic rearm(input int s);
        start_v[s] = 1'b1;
        tick();
    endtask

    // Frame model: line carries {stop, word, start} one bit per cpb cycles
    // from the trigger edge; done pulses once on edge 10*cpb+1.
    task automatic run_frame(input int s, input logic [7:0] w, input int cpb,
                             input int glitch_at, input int abort_at, input int tail);
        logic [9:0] frame;
        logic       aborted;
        int         n;
        frame   = {1'b1, w, 1'b0};
        n       = 10 * cpb + 1;
        aborted = 1'b0;
        din_v[s]   = w;
        start_v[s] = 1'b0;
        tick();
        for (int k = 0; k <= n + tail; k++) begin
            logic el;
            logic ed;
            if (aborted || k >= 10 * cpb) el = 1'b1;
            else el = frame[k / cpb];
            ed = !aborted && (k == n);
            if (ed) exp_dout[s] = w;
            chk($sformatf("line_s%0d_k%0d", s, k), {7'd0, line_v[s]}, {7'd0, el});
            chk($sformatf("done_s%0d_k%0d", s, k), {7'd0, done_v[s]}, {7'd0, ed});
            chk($sformatf("dout_s%0d_k%0d", s, k), dout_v[s], exp_dout[s]);
            stop_v[s] = 1'b0;
            if (k == 1) din_v[s] = 8'($urandom);
            if (glitch_at >= 0 && k == glitch_at) start_v[s] = 1'b1;
            if (glitch_at >= 0 && k == glitch_at + 1) begin
                start_v[s] = 1'b0;
                din_v[s]   = 8'hFF;
            end
            if (k == abort_at) begin
                stop_v[s] = 1'b1;
                aborted   = 1'b1;
            end
            tick();
        end
        stop_v[s] = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b0;
        for (int s = 0; s < 2; s++) begin
            start_v[s]  = 1'b1;
            stop_v[s]   = 1'b0;
            din_v[s]    = 8'h00;
            exp_dout[s] = 8'h00;
        end
        #2 rst = 1'b1;
        #1;
        chk_idle(0, "reset1");
        chk_idle(1, "reset4");
        tick();
        tick();
        rst = 1'b0;
        tick();

        run_frame(0, 8'h81, 1, -1, -1, 10);   // start held low: no retrigger
        rearm(0);
        run_frame(0, 8'hA5, 1, -1, -1, 0);
        rearm(0);
        run_frame(0, 8'h3C, 1, -1, -1, 3);
        rearm(0);
        run_frame(0, 8'h96, 1, 4, -1, 4);     // falling edge while busy ignored
        rearm(0);
        run_frame(0, 8'h81, 1, -1, -1, 0);
        rearm(0);
        run_frame(0, 8'h55, 1, -1, 5, 4);     // aborted frame
        rearm(0);
        run_frame(0, 8'h55, 1, -1, -1, 0);
        rearm(0);

        // Trigger coinciding with stop is discarded.
        start_v[0] = 1'b0;
        stop_v[0]  = 1'b1;
        tick();
        stop_v[0] = 1'b0;
        for (int k = 0; k < 12; k++) begin
            chk_idle(0, $sformatf("stoptrig_k%0d", k));
            tick();
        end
        rearm(0);

        for (int i = 0; i < 4; i++) begin
            run_frame(0, 8'($urandom), 1, -1, -1, 1);
            rearm(0);
        end

        // Asynchronous reset in the middle of a frame.
        din_v[0]   = 8'h5B;
        start_v[0] = 1'b0;
        tick();
        tick();
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        exp_dout[0] = 8'h00;
        exp_dout[1] = 8'h00;
        chk_idle(0, "midrst1");
        chk_idle(1, "midrst4");
        start_v[0] = 1'b1;
        #1 rst = 1'b0;
        tick();
        run_frame(0, 8'hC3, 1, -1, -1, 2);
        rearm(0);

        run_frame(1, 8'h5A, 4, -1, -1, 3);
        rearm(1);
        run_frame(1, 8'($urandom), 4, 9, -1, 2);
        rearm(1);
        run_frame(1, 8'($urandom), 4, -1, 17, 3);
        rearm(1);
        run_frame(1, 8'($urandom), 4, -1, -1, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_simplex.md
Name: uart_simplex

Overview:
- Self-contained simplex UART link: a transmitter serializes an 8-bit word onto an internal serial line, and a receiver on the same line deserializes it back.
- The received word appears on dout and is flagged by a one-cycle done pulse.
- Used as a loopback/bring-up block for UART framing: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).

Parameters:
- CLKS_PER_BIT, 1, clock cycles per serial bit period; must be ≥1.
- DATA_W, 8, data word width; fixed at 8 for this block.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- start  input  1  active-low transmit trigger; a registered 1→0 transition launches one frame
- stop  input  1  active-high synchronous abort of any frame in progress
- din  input  8  word to transmit, sampled on the trigger edge
- dout  output  8  last correctly received word
- done  output  1  one-cycle pulse when a valid frame has been received

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset values:
  - dout=8'h00, done=0.
  - Internal serial line = 1 (idle/mark).
  - TX and RX in IDLE.
  - start-edge register = 1.
- Trigger: start is registered every cycle. A frame launches only when the registered value was 1, start is now 0, TX is IDLE and stop=0. On that edge din is loaded into the TX shift register. Holding start low does not retrigger; start must return high first. Falling edges while TX is busy are ignored.
- TX FSM: IDLE → START (line=0) → DATA (bits 0..7, LSB first) → STOP (line=1) → IDLE.
  - Each state/bit holds for exactly CLKS_PER_BIT cycles, counted by a bit-period counter.
  - Full frame = 10*CLKS_PER_BIT cycles.
  - TX may launch a new frame on the cycle after it returns to IDLE.
- RX FSM: IDLE → DATA → STOP → IDLE.
  - In IDLE, line=0 starts the timing of a frame.
  - Each bit is sampled on the last cycle of its bit period.
  - Data bits shift in LSB first.
  - On the stop-bit sample:
    - If line=1: dout ← assembled word and done=1 for exactly one cycle (registered).
    - If line=0 (framing error): dout unchanged, no done, RX returns to IDLE.
- Latency: done rises on the (10*CLKS_PER_BIT+1)-th rising edge after the trigger edge. dout updates on that same edge and holds until the next valid frame.
- stop=1 (any cycle):
  - TX and RX return to IDLE, line=1, counters cleared.
  - done forced 0, dout retains its value.
  - A trigger coinciding with stop=1 is discarded.
- Reset mid-frame: immediate return to reset values; no done is produced for the partial frame.
- din changes after the trigger edge do not affect the frame in flight.

Decomposition:
- Shared package uart_pkg:
  - DATA_W constant.
  - Frame bit constants START_BIT=1'b0, STOP_BIT=1'b1.
  - Typedefs for TX state (IDLE/START/DATA/STOP) and RX state (IDLE/DATA/STOP).
- One natural sub-module: uart_simplex_rx, containing the receiver FSM, sampler and shift register, fed by the internal line.
- The transmitter, trigger-edge logic and abort logic stay in the top level.

Test Plan:
- Reset, then din=8'h81, start 1→0 held low 10 cycles, CLKS_PER_BIT=1 → line shows 0,1,0,0,0,0,0,0,1,1; done pulses once on the 11th edge; dout=8'h81; no second frame while start stays low.
- Back-to-back: 8'hA5 sent, start high→low again right after done with din=8'h3C → done pulses twice; dout=8'hA5, then 8'h3C.
- Falling edge of start at cycle 4 of a frame (din changed to 8'hFF) → ignored; dout=original word; exactly one done.
- stop=1 for one cycle at cycle 5 of a frame with din=8'h55 (dout previously 8'h81) → no done; dout stays 8'h81; line=1; next trigger sends correctly.
- rst asserted asynchronously mid-frame → dout=8'h00, done=0, line=1 immediately; a subsequent frame of 8'hC3 is received correctly.
- CLKS_PER_BIT=4, din=8'h5A → each bit lasts 4 cycles; done on the 41st edge; dout=8'h5A.
